rlc_onchip_mem_arbiter: RTL and testbench
=========================================

// Module: rlc_onchip_mem_arbiter
// PURPOSE
//  Two-master arbiter for the single-port 32-bit on-chip RAM (50000 words, 1-cycle read latency).
//  Lets the CPU data master (m0) and the game-graphics fetch master (m1) share the RAM.
//  Round-robin arbitration with a bounded back-to-back hold.
//  Routes readdata back to the issuing master with a readdatavalid strobe.
// PARAMETERS
//  DEPTH     50000  valid word addresses 0..DEPTH-1
//  ADDR_W    16     word address width
//  HOLD_MAX  4      max consecutive grants to one master while the other is requesting (>=1)
// PORTS
//  clk                 in   1   system clock
//  reset_n             in   1   asynchronous active-low reset
//  mN_address (N=0,1)  in   16  requester word address
//  mN_read             in   1   read request
//  mN_write            in   1   write request
//  mN_byteenable       in   4   write byte lanes
//  mN_writedata        in   32  write data
//  mN_waitrequest      out  1   1 = command not accepted this cycle; hold it stable
//  mN_readdata         out  32  read data, valid with mN_readdatavalid
//  mN_readdatavalid    out  1   one-cycle read-return strobe
//  mem_address         out  16  to RAM address
//  mem_chipselect      out  1   to RAM chipselect
//  mem_write           out  1   to RAM write
//  mem_byteenable      out  4   to RAM byteenable
//  mem_writedata       out  32  to RAM writedata
//  mem_clken           out  1   to RAM clken; 1 when reset_n high
//  mem_readdata        in   32  from RAM q (valid the cycle after the read is issued)
// BEHAVIOUR
//  - Reset (reset_n low, async):
//    - last_grant=1, hold_cnt=0, rd_pend=0, rd_tag=0.
//    - mN_readdatavalid=0, mN_waitrequest=1, mem_chipselect=0, mem_write=0, mem_clken=0.
//  - Request: reqN = mN_read | mN_write. If both read and write are asserted, it is a write; no read return.
//  - Grant (combinational, from registered state and inputs):
//    - Only m0 or only m1 requesting: that master wins.
//    - Both requesting: the master != last_grant wins, unless last_grant's master has hold_cnt < HOLD_MAX-1 and was granted last cycle.
//    - At most one grant per cycle. Winner's waitrequest=0; loser's waitrequest=1.
//    - Idle master: waitrequest=1. 100% throughput, one command per cycle.
//  - Issue cycle T: mem_* = winner's fields, mem_chipselect=1, mem_write=winner's write.
//  - Clock edge closing T:
//    - last_grant <= winner.
//    - hold_cnt <= (winner==last_grant && granted in T-1) ? hold_cnt+1 : 0; saturates at HOLD_MAX-1.
//    - Read: rd_pend<=1, rd_tag<=winner.
//  - T+1: mN_readdatavalid=1 for N==rd_tag, with mN_readdata=mem_readdata.
//    - The other master sees readdatavalid=0.
//    - A new command may issue in the same cycle (pipelined).
//  - mN_readdata is driven with mem_readdata at all times; it is meaningful only with readdatavalid.
//  - Out of range (address >= DEPTH):
//    - Still granted and acked; mem_chipselect=0, so there is no RAM access.
//    - Writes are dropped.
//    - Reads return readdatavalid at T+1 with readdata=32'h0 (registered oob flag selects 0).
//  - No grant: mem_chipselect=0, mem_write=0, mem_address holds its last value (registered mux select).
//  - Reset mid-read: rd_pend is cleared; no readdatavalid after release. The first grant after reset uses last_grant=1, so m0 wins a tie.
//  - Starvation bound: with both masters continuously requesting, each waits at most HOLD_MAX cycles.
// TESTING
//  - Reset: hold reset_n=0 with both masters requesting -> waitrequest=1, chipselect=0, no readdatavalid; release -> m0 granted first.
//  - m0 write addr 16'h0010 data 32'hDEADBEEF be 4'hF, then m1 read 16'h0010 -> m1_readdatavalid 1 cycle after accept, data DEADBEEF; m0_readdatavalid stays 0.
//  - Both masters read continuously, HOLD_MAX=4 -> grant pattern m0 x4, m1 x4, ...; one accept every cycle; no master waits >4 cycles.
//  - Byte write be=4'b0010 data 32'h0000AB00 over 32'h11223344 at 16'h0020 -> readback 32'h1122AB44.
//  - m1 write then read at address 50000 -> write does not alter word 0; read returns 32'h0 with readdatavalid.
//  - Assert reset_n=0 in the cycle after a read accept -> no readdatavalid is ever produced for that read.

Source files
------------

// File: rtl/rlc_onchip_mem_arbiter.sv
// Two-master round-robin arbiter for the single-port on-chip RAM.
// One command per cycle, bounded back-to-back hold, tagged 1-cycle read return.
module rlc_onchip_mem_arbiter #(
  parameter int unsigned DEPTH    = 50000,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  localparam int unsigned HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MAX - 1);

  logic            last_grant;
  logic            granted_q;
  logic [HC_W-1:0] hold_cnt;
  logic            rd_pend;
  logic            rd_tag;
  logic            rd_oob;

  logic            req0, req1;
  logic            grant, win, mux_sel;
  logic            in_range, is_write, is_read;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    req0     = reset_n & (m0_read | m0_write);
    req1     = reset_n & (m1_read | m1_write);
    grant    = req0 | req1;
    win      = 1'b0;
    if (req0 && req1) begin
      // Previous winner keeps the port only while it is mid-burst and under the hold limit.
      if (granted_q && (hold_cnt < HOLD_LIM))
        win = last_grant;
      else
        win = ~last_grant;
    end else begin
      win = req1;
    end

    // With no grant the mux stays on the last winner so mem_address does not toggle.
    mux_sel  = grant ? win : last_grant;
    sel_addr = mux_sel ? m1_address : m0_address;
    is_write = win ? m1_write : m0_write;
    is_read  = (win ? m1_read : m0_read) & ~is_write;
    in_range = 32'(sel_addr) < DEPTH;

    mem_address    = sel_addr;
    mem_byteenable = mux_sel ? m1_byteenable : m0_byteenable;
    mem_writedata  = mux_sel ? m1_writedata  : m0_writedata;
    mem_chipselect = grant & in_range;
    mem_write      = grant & in_range & is_write;

    m0_waitrequest = ~(grant & ~win);
    m1_waitrequest = ~(grant & win);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      granted_q  <= 1'b0;
      hold_cnt   <= '0;
      rd_pend    <= 1'b0;
      rd_tag     <= 1'b0;
      rd_oob     <= 1'b0;
    end else begin
      granted_q <= grant;
      rd_pend   <= grant & is_read;
      if (grant) begin
        last_grant <= win;
        if ((win == last_grant) && granted_q)
          hold_cnt <= (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + 1'b1;
        else
          hold_cnt <= '0;
        if (is_read) begin
          rd_tag <= win;
          rd_oob <= ~in_range;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  always_comb begin
    m0_readdatavalid = rd_pend & ~rd_tag;
    m1_readdatavalid = rd_pend & rd_tag;
    m0_readdata      = rd_oob ? '0 : mem_readdata;
    m1_readdata      = rd_oob ? '0 : mem_readdata;
    mem_clken        = reset_n;
  end

endmodule

// File: tb/tb_rlc_onchip_mem_arbiter.sv
// Directed bench for rlc_onchip_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_rlc_onchip_mem_arbiter;

  localparam int unsigned DEPTH = 50000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [15:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] ram [0:DEPTH-1];

  always #5 clk = ~clk;

  rlc_onchip_mem_arbiter #(.DEPTH(DEPTH), .ADDR_W(16), .HOLD_MAX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // Single-port RAM: byte-lane writes, registered read data.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
  endtask

  // Issue one command from master m, confirm it is accepted, then check the return cycle.
  task automatic do_cmd(input logic m, input logic rd, input logic wr,
                        input logic [15:0] addr, input logic [3:0] be,
                        input logic [31:0] data, input logic exp_cs,
                        input logic [31:0] exp_rd);
    if (m) begin
      m1_read = rd; m1_write = wr; m1_address = addr; m1_byteenable = be; m1_writedata = data;
    end else begin
      m0_read = rd; m0_write = wr; m0_address = addr; m0_byteenable = be; m0_writedata = data;
    end
    @(negedge clk);
    check("accept", {31'b0, m ? m1_waitrequest : m0_waitrequest}, 32'd0);
    check("other_wait", {31'b0, m ? m0_waitrequest : m1_waitrequest}, 32'd1);
    check("chipselect", {31'b0, mem_chipselect}, {31'b0, exp_cs});
    step();
    clear_reqs();
    @(negedge clk);
    if (rd && !wr) begin
      check("rdv_own", {31'b0, m ? m1_readdatavalid : m0_readdatavalid}, 32'd1);
      check("rdv_other", {31'b0, m ? m0_readdatavalid : m1_readdatavalid}, 32'd0);
      check("rdata", m ? m1_readdata : m0_readdata, exp_rd);
    end else begin
      check("rdv_none", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;

    // Reset with both masters requesting.
    m0_read = 1'b1; m0_address = 16'h0001;
    m1_read = 1'b1; m1_address = 16'h0002;
    repeat (3) @(negedge clk);
    check("rst_m0_wait", {31'b0, m0_waitrequest}, 32'd1);
    check("rst_m1_wait", {31'b0, m1_waitrequest}, 32'd1);
    check("rst_cs", {31'b0, mem_chipselect}, 32'd0);
    check("rst_clken", {31'b0, mem_clken}, 32'd0);
    check("rst_rdv", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("first_m0_wait", {31'b0, m0_waitrequest}, 32'd0);
    check("first_m1_wait", {31'b0, m1_waitrequest}, 32'd1);
    check("clken_on", {31'b0, mem_clken}, 32'd1);
    step();
    clear_reqs();
    @(negedge clk);
    check("first_rdv", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd1);
    step();

    // m0 write, m1 reads it back.
    do_cmd(1'b0, 1'b0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0);
    do_cmd(1'b1, 1'b1, 1'b0, 16'h0010, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF);

    // Both masters read continuously: m0 x4, m1 x4, ...
    m0_read = 1'b1; m0_address = 16'h0010;
    m1_read = 1'b1; m1_address = 16'h0020;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("rr_m0_wait", {31'b0, m0_waitrequest}, {31'b0, ((i / 4) % 2) == 1});
      check("rr_m1_wait", {31'b0, m1_waitrequest}, {31'b0, ((i / 4) % 2) == 0});
      if (i > 0) begin
        check("rr_rdv", {30'b0, m1_readdatavalid, m0_readdatavalid},
              (((i - 1) / 4) % 2 == 1) ? 32'd2 : 32'd1);
        check("rr_rdata", m0_readdata, (((i - 1) / 4) % 2 == 1) ? 32'h0 : 32'hDEADBEEF);
      end
      step();
    end
    clear_reqs();
    @(negedge clk);
    check("rr_last_rdv", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd2);
    step();

    // Byte-lane write.
    do_cmd(1'b0, 1'b0, 1'b1, 16'h0020, 4'hF, 32'h11223344, 1'b1, 32'h0);
    do_cmd(1'b0, 1'b0, 1'b1, 16'h0020, 4'b0010, 32'h0000AB00, 1'b1, 32'h0);
    do_cmd(1'b0, 1'b1, 1'b0, 16'h0020, 4'h0, 32'h0, 1'b1, 32'h1122AB44);

    // Out-of-range accesses at DEPTH.
    do_cmd(1'b0, 1'b0, 1'b1, 16'h0000, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0);
    do_cmd(1'b1, 1'b0, 1'b1, 16'd50000, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0);
    do_cmd(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 32'h0, 1'b1, 32'hCAFEF00D);
    do_cmd(1'b1, 1'b1, 1'b0, 16'd50000, 4'h0, 32'h0, 1'b0, 32'h0);
    do_cmd(1'b1, 1'b1, 1'b1, 16'h0000, 4'hF, 32'h12345678, 1'b1, 32'h0);
    do_cmd(1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 32'h0, 1'b1, 32'h12345678);

    // Reset in the cycle after a read accept: the return must never appear.
    m0_read = 1'b1; m0_address = 16'h0010;
    @(negedge clk);
    check("mid_accept", {31'b0, m0_waitrequest}, 32'd0);
    step();
    clear_reqs();
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_rdv", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
      step();
      if (i == 1) reset_n = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
